// File: rtl/pp_pipeline_accel_fifo2axis_pkg.sv
// Shared types and constants for the pp_pipeline_accel FIFO-to-AXI4-Stream converter.
package pp_pipeline_accel_fifo2axis_pkg;

    localparam int DATA_WIDTH = 11;
    localparam int DIM_WIDTH  = 11;
    localparam int OBUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic                  user;
    } obuf_entry_t;

endpackage

// File: rtl/pp_pipeline_accel_fifo2axis_obuf.sv
// Two-entry output buffer; head is stable until popped, push+pop in one cycle keeps the count.
module pp_pipeline_accel_fifo2axis_obuf
    import pp_pipeline_accel_fifo2axis_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  obuf_entry_t entry_in,
    input  logic        pop,
    output obuf_entry_t head,
    output logic [1:0]  count,
    output logic        full
);

    obuf_entry_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign full    = (count == 2'd2);
    assign do_pop  = pop && (count != 2'd0);
    // A full buffer only accepts a word when its head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= entry_in;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pp_pipeline_accel_fifo2axis_w11.sv
// Pops the 11-bit FWFT FIFO and emits a framed video stream (tuser=SOF, tlast=EOL).
// Optional PP_FIFO2AXIS_PERF_EN adds stall/starve cycle counters.
module pp_pipeline_accel_fifo2axis_w11
    import pp_pipeline_accel_fifo2axis_pkg::*;
#(
    parameter int DATA_WIDTH = pp_pipeline_accel_fifo2axis_pkg::DATA_WIDTH,
    parameter int DIM_WIDTH  = pp_pipeline_accel_fifo2axis_pkg::DIM_WIDTH,
    parameter int OBUF_DEPTH = pp_pipeline_accel_fifo2axis_pkg::OBUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_done,
    output logic                  ap_idle,
    input  logic [DIM_WIDTH-1:0]  cfg_rows,
    input  logic [DIM_WIDTH-1:0]  cfg_cols,
    input  logic                  fifo_empty_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_read,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    output logic                  m_tuser
`ifdef PP_FIFO2AXIS_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           starve_cycles
`endif
);

    if (OBUF_DEPTH != 2) begin : g_bad_depth
        $error("OBUF_DEPTH must be 2");
    end
    if (DATA_WIDTH != pp_pipeline_accel_fifo2axis_pkg::DATA_WIDTH) begin : g_bad_width
        $error("DATA_WIDTH must match the package entry width");
    end

    localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);

    state_t                state;
    state_t                state_nxt;
    logic [DIM_WIDTH-1:0]  row;
    logic [DIM_WIDTH-1:0]  col;
    logic [DIM_WIDTH-1:0]  rows_m1;
    logic [DIM_WIDTH-1:0]  cols_m1;
    obuf_entry_t           entry_in;
    obuf_entry_t           head;
    logic [1:0]            obuf_count;
    logic                  obuf_full;
    logic                  beat;
    logic                  start_ok;
    logic                  zero_dim;
    logic                  last_word;
    logic                  col_end;

    assign beat      = (obuf_count != 2'd0) && m_tready;
    assign start_ok  = (state == IDLE) && ap_start;
    assign zero_dim  = (cfg_rows == '0) || (cfg_cols == '0);
    assign col_end   = (col == cols_m1);
    assign last_word = (row == rows_m1) && col_end;
    // Words remain exactly while in RUN: the final pop moves the FSM to DRAIN.
    assign fifo_read = (state == RUN) && fifo_empty_n && (!obuf_full || beat);

    always_comb begin
        entry_in      = '0;
        entry_in.data = fifo_dout;
        entry_in.last = col_end;
        entry_in.user = (row == '0) && (col == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ap_ready  = 1'b0;
        ap_done   = 1'b0;
        ap_idle   = 1'b0;
        unique case (state)
            IDLE: begin
                ap_idle  = 1'b1;
                ap_ready = ap_start;
                if (ap_start)
                    state_nxt = zero_dim ? DONE : RUN;
            end
            RUN: begin
                if (fifo_read && last_word)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if ((obuf_count == 2'd0) || ((obuf_count == 2'd1) && beat))
                    state_nxt = DONE;
            end
            DONE: begin
                ap_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row     <= '0;
            col     <= '0;
            rows_m1 <= '0;
            cols_m1 <= '0;
        end else if (start_ok) begin
            row     <= '0;
            col     <= '0;
            rows_m1 <= cfg_rows - DIM_ONE;
            cols_m1 <= cfg_cols - DIM_ONE;
        end else if (fifo_read) begin
            if (col_end) begin
                col <= '0;
                row <= row + DIM_ONE;
            end else begin
                col <= col + DIM_ONE;
            end
        end
    end

    pp_pipeline_accel_fifo2axis_obuf u_obuf (
        .clk      (clk),
        .rst      (reset),
        .push     (fifo_read),
        .entry_in (entry_in),
        .pop      (m_tready),
        .head     (head),
        .count    (obuf_count),
        .full     (obuf_full)
    );

    // Payload is forced to zero when idle so the bus is quiet between frames.
    assign m_tvalid = (obuf_count != 2'd0);
    assign m_tdata  = m_tvalid ? head.data : '0;
    assign m_tlast  = m_tvalid && head.last;
    assign m_tuser  = m_tvalid && head.user;

`ifdef PP_FIFO2AXIS_PERF_EN
    logic stall_hit;
    logic starve_hit;

    assign stall_hit  = ((state == RUN) || (state == DRAIN)) && m_tvalid && !m_tready;
    assign starve_hit = (state == RUN) && !obuf_full && !fifo_empty_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles  <= '0;
            starve_cycles <= '0;
        end else if (start_ok) begin
            stall_cycles  <= '0;
            starve_cycles <= '0;
        end else begin
            if (stall_hit && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if (starve_hit && (starve_cycles != '1))
                starve_cycles <= starve_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_fifo2axis_w11.sv
// Randomized self-checking bench: a queue-style FIFO model feeds the DUT, beats are
// scoreboarded against framing computed from rows/cols and the words the bench wrote.
`timescale 1ns/1ps
module tb_pp_pipeline_accel_fifo2axis_w11;

    localparam int DW = 11;
    localparam int MW = 11;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ap_start = 1'b0;
    logic          ap_ready, ap_done, ap_idle;
    logic [MW-1:0] cfg_rows = '0;
    logic [MW-1:0] cfg_cols = '0;
    logic          fifo_empty_n;
    logic [DW-1:0] fifo_dout;
    logic          fifo_read;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tlast, m_tuser;
`ifdef PP_FIFO2AXIS_PERF_EN
    logic [31:0]   stall_cycles, starve_cycles;
`endif

    always #5 clk = ~clk;

    pp_pipeline_accel_fifo2axis_w11 dut (
        .clk          (clk),
        .reset        (reset),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_idle      (ap_idle),
        .cfg_rows     (cfg_rows),
        .cfg_cols     (cfg_cols),
        .fifo_empty_n (fifo_empty_n),
        .fifo_dout    (fifo_dout),
        .fifo_read    (fifo_read),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast),
        .m_tuser      (m_tuser)
`ifdef PP_FIFO2AXIS_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .starve_cycles(starve_cycles)
`endif
    );

    // Upstream FIFO model: words at fmem[rd..wr-1]; cleared by the shared reset.
    logic [DW-1:0] fmem [0:4095];
    int            rd = 0;
    int            wr = 0;
    logic          fifo_hold;
    always @(posedge clk or posedge reset)
        if (reset) rd <= wr;
        else if (fifo_read) rd <= rd + 1;
    assign fifo_empty_n = (rd != wr) && !fifo_hold;
    assign fifo_dout    = fmem[rd[11:0]];

    // Sink/source pacing: automatic modes or manual overrides from the tests.
    int       rdy_mode = 0;
    bit       hold_rand = 0;
    bit       man = 0;
    logic     rdy_man = 1'b1, hold_man = 1'b0;
    logic     rdy_auto = 1'b1, hold_auto = 1'b0;
    logic [3:0] pat = 4'b1001;
    int       pi = 0;
    assign m_tready  = man ? rdy_man : rdy_auto;
    assign fifo_hold = man ? hold_man : hold_auto;

    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       rdy_auto = 1'b1;
            1:       begin rdy_auto = pat[pi]; pi = (pi + 1) % 4; end
            default: rdy_auto = ($urandom_range(0, 99) < 60);
        endcase
        hold_auto = hold_rand && ($urandom_range(0, 99) < 25);
    end

    // Monitor: records beats and protocol violations on the falling edge.
    int    cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    beat_t got_q [$];
    int    got_cyc [$];
    int    n_rd = 0, n_vld = 0, n_ready = 0, n_done = 0, done_cyc = 0, ready_cyc = 0;
    int    stab_err = 0, full_err = 0, occ_err = 0, wide_done = 0;
    int    occ = 0;
    logic  prev_stall = 1'b0, prev_done = 1'b0;
    beat_t prev_b = '0;

    always @(negedge clk) begin
        if (reset) begin
            occ        = 0;
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall && (!m_tvalid || beat_t'({m_tdata, m_tlast, m_tuser}) != prev_b))
                stab_err++;
            if (fifo_read && occ >= 2 && !(m_tvalid && m_tready)) full_err++;
            if (m_tvalid != (occ != 0)) occ_err++;
            if (ap_done && prev_done) wide_done++;
            if (ap_done) begin n_done++; done_cyc = cyc; end
            if (ap_ready) begin n_ready++; ready_cyc = cyc; end
            if (fifo_read) n_rd++;
            if (m_tvalid) n_vld++;
            if (m_tvalid && m_tready) begin
                got_q.push_back({m_tdata, m_tlast, m_tuser});
                got_cyc.push_back(cyc);
            end
            occ        = occ + int'(fifo_read) - int'(m_tvalid && m_tready);
            prev_stall = m_tvalid && !m_tready;
            prev_b     = {m_tdata, m_tlast, m_tuser};
            prev_done  = ap_done;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic push(input logic [DW-1:0] v);
        fmem[wr[11:0]] = v;
        wr++;
    endtask

    task automatic start(input int r, input int c);
        @(posedge clk); #1;
        cfg_rows = MW'(r);
        cfg_cols = MW'(c);
        ap_start = 1'b1;
        @(posedge clk); #1;
        ap_start = 1'b0;
        cfg_rows = MW'($urandom);
        cfg_cols = MW'($urandom);
    endtask

    task automatic wait_done(input int d0, input int bound, output bit ok);
        ok = 0;
        for (int k = 0; k < bound; k++) begin
            @(posedge clk); #1;
            if (n_done > d0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({m_tvalid, m_tlast, m_tuser, ap_ready, ap_done, fifo_read, m_tdata} !== '0 || ap_idle !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in: v%b l%b u%b rdy%b done%b rd%b d%h idle%b, want all 0 idle 1",
                     m_tvalid, m_tlast, m_tuser, ap_ready, ap_done, fifo_read, m_tdata, ap_idle);
        end
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({m_tvalid, m_tlast, m_tuser, ap_ready, ap_done, fifo_read, m_tdata} !== '0 || ap_idle !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_out: v%b idle%b rd%b d%h, want 0/1/0/0", m_tvalid, ap_idle, fifo_read, m_tdata);
        end
    endtask

    task automatic test_basic();
        int g0, d0, r0, rd0, n;
        bit ok;
        man = 0; rdy_mode = 0; hold_rand = 0;
        @(posedge clk); #1;
        rd0 = rd; g0 = got_q.size(); d0 = n_done; r0 = n_ready;
        for (int i = 1; i <= 6; i++) push(DW'(i));
        start(2, 3);
        wait_done(d0, 100, ok);
        repeat (2) @(posedge clk); #1;
        n = got_q.size() - g0;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_done: no ap_done within 100 cycles"); end
        n_cmp++; if (n != 6) begin n_bad++; $display("FAIL basic_count: got %0d beats want 6", n); end
        for (int i = 0; i < 6 && i < n; i++) begin
            beat_t e;
            e.data = DW'(i + 1);
            e.last = (i % 3) == 2;
            e.user = (i == 0);
            n_cmp++;
            if (got_q[g0 + i] !== e) begin
                n_bad++;
                $display("FAIL basic_beat%0d: got %h/%b/%b want %h/%b/%b", i, got_q[g0+i].data,
                         got_q[g0+i].last, got_q[g0+i].user, e.data, e.last, e.user);
            end
        end
        if (n == 6) begin
            n_cmp++;
            if (got_cyc[g0+5] - got_cyc[g0] != 5) begin
                n_bad++; $display("FAIL basic_rate: 6 beats over %0d cycles want 5", got_cyc[g0+5] - got_cyc[g0]);
            end
            n_cmp++;
            if (done_cyc != got_cyc[g0+5] + 1) begin
                n_bad++; $display("FAIL basic_done_lat: done cyc %0d want %0d", done_cyc, got_cyc[g0+5] + 1);
            end
        end
        n_cmp++; if (n_ready - r0 != 1) begin n_bad++; $display("FAIL basic_ready: %0d pulses want 1", n_ready - r0); end
        n_cmp++; if (n_done - d0 != 1 || wide_done != 0) begin
            n_bad++; $display("FAIL basic_done_pulse: %0d pulses (%0d wide) want 1 narrow", n_done - d0, wide_done);
        end
        n_cmp++; if (rd - rd0 != 6) begin n_bad++; $display("FAIL basic_pops: %0d want 6", rd - rd0); end
    endtask

    task automatic test_backpressure();
        int g0, d0, rd0, n;
        bit ok;
        man = 0; rdy_mode = 1; hold_rand = 0;
        @(posedge clk); #1;
        rd0 = rd; g0 = got_q.size(); d0 = n_done;
        for (int i = 0; i < 6; i++) push(DW'(12'h101 + i));
        start(2, 3);
        wait_done(d0, 200, ok);
        repeat (2) @(posedge clk); #1;
        n = got_q.size() - g0;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_done: no ap_done within 200 cycles"); end
        n_cmp++; if (n != 6) begin n_bad++; $display("FAIL bp_count: got %0d beats want 6", n); end
        for (int i = 0; i < 6 && i < n; i++) begin
            beat_t e;
            e.data = fmem[rd0 + i];
            e.last = (i % 3) == 2;
            e.user = (i == 0);
            n_cmp++;
            if (got_q[g0 + i] !== e) begin
                n_bad++; $display("FAIL bp_beat%0d: got %h want %h", i, got_q[g0+i], e);
            end
        end
        n_cmp++; if (stab_err != 0) begin n_bad++; $display("FAIL bp_stable: %0d unstable stalls want 0", stab_err); end
        n_cmp++; if (full_err != 0) begin n_bad++; $display("FAIL bp_full_read: %0d reads while full want 0", full_err); end
        n_cmp++; if (occ_err != 0) begin n_bad++; $display("FAIL bp_latency: %0d tvalid/occupancy errors want 0", occ_err); end
    endtask

    task automatic test_single();
        int g0, d0, r0, n;
        bit ok;
        man = 0; rdy_mode = 0; hold_rand = 0;
        @(posedge clk); #1;
        g0 = got_q.size(); d0 = n_done; r0 = n_ready;
        push(11'h7FF);
        start(1, 1);
        wait_done(d0, 50, ok);
        repeat (2) @(posedge clk); #1;
        n = got_q.size() - g0;
        n_cmp++; if (!ok || n != 1) begin n_bad++; $display("FAIL single_count: ok %0d beats %0d want 1/1", ok, n); end
        if (n >= 1) begin
            n_cmp++;
            if (got_q[g0] !== beat_t'({11'h7FF, 1'b1, 1'b1})) begin
                n_bad++; $display("FAIL single_beat: got %h want %h", got_q[g0], beat_t'({11'h7FF, 1'b1, 1'b1}));
            end
        end
        n_cmp++; if (n_ready - r0 != 1 || n_done - d0 != 1) begin
            n_bad++; $display("FAIL single_hs: ready %0d done %0d want 1/1", n_ready - r0, n_done - d0);
        end
    endtask

    task automatic test_zero_dim();
        int dims [2][2] = '{'{3, 0}, '{0, 5}};
        for (int t = 0; t < 2; t++) begin
            int d0, rd0, nr0, nv0, lat;
            bit ok;
            man = 0; rdy_mode = 0; hold_rand = 0;
            @(posedge clk); #1;
            push(DW'($urandom)); push(DW'($urandom));
            rd0 = rd; d0 = n_done; nr0 = n_rd; nv0 = n_vld;
            start(dims[t][0], dims[t][1]);
            wait_done(d0, 10, ok);
            repeat (3) @(posedge clk); #1;
            lat = done_cyc - ready_cyc;
            n_cmp++; if (!ok || lat < 1 || lat > 2) begin
                n_bad++; $display("FAIL zero%0d_done: ok %0d latency %0d want 1..2", t, ok, lat);
            end
            n_cmp++; if (n_rd != nr0 || rd != rd0) begin
                n_bad++; $display("FAIL zero%0d_reads: %0d reads want 0", t, n_rd - nr0);
            end
            n_cmp++; if (n_vld != nv0) begin n_bad++; $display("FAIL zero%0d_valid: %0d valid cycles want 0", t, n_vld - nv0); end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            int r, c, x, g0, d0, rd0, n;
            bit ok;
            man = 0; rdy_mode = 2; hold_rand = 1;
            r = $urandom_range(1, 4); c = $urandom_range(1, 6); x = $urandom_range(0, 3);
            @(posedge clk); #1;
            rd0 = rd; g0 = got_q.size(); d0 = n_done;
            for (int i = 0; i < r * c + x; i++) push(DW'($urandom));
            start(r, c);
            wait_done(d0, 40 * r * c + 50, ok);
            repeat (2) @(posedge clk); #1;
            n = got_q.size() - g0;
            n_cmp++; if (!ok || n != r * c) begin
                n_bad++; $display("FAIL rand%0d_count: ok %0d beats %0d want %0d (%0dx%0d)", f, ok, n, r * c, r, c);
            end
            for (int i = 0; i < r * c && i < n; i++) begin
                beat_t e;
                e.data = fmem[rd0 + i];
                e.last = (i % c) == c - 1;
                e.user = (i == 0);
                n_cmp++;
                if (got_q[g0 + i] !== e) begin
                    n_bad++; $display("FAIL rand%0d_beat%0d: got %h want %h", f, i, got_q[g0+i], e);
                end
            end
            n_cmp++; if (rd - rd0 != r * c) begin
                n_bad++; $display("FAIL rand%0d_left: popped %0d want %0d", f, rd - rd0, r * c);
            end
        end
        n_cmp++; if (stab_err + full_err + occ_err != 0) begin
            n_bad++; $display("FAIL rand_protocol: stab %0d full %0d occ %0d want 0", stab_err, full_err, occ_err);
        end
    endtask

    task automatic test_reset_mid();
        int g0, d0, n, k;
        bit ok;
        man = 1; rdy_man = 1'b1; hold_man = 1'b0;
        @(posedge clk); #1;
        g0 = got_q.size();
        for (int i = 0; i < 16; i++) push(DW'($urandom));
        start(4, 4);
        for (k = 0; k < 100 && got_q.size() - g0 < 5; k++) begin @(posedge clk); #1; end
        rdy_man = 1'b0;
        n_cmp++; if (got_q.size() - g0 != 5) begin n_bad++; $display("FAIL rmid_beats: %0d beats want 5", got_q.size() - g0); end
        @(posedge clk); #2;
        n_cmp++; if (m_tvalid !== 1'b1) begin n_bad++; $display("FAIL rmid_pre: tvalid %b want 1", m_tvalid); end
        reset = 1'b1;
        #1;
        n_cmp++; if (m_tvalid !== 1'b0 || ap_idle !== 1'b1 || fifo_read !== 1'b0) begin
            n_bad++; $display("FAIL rmid_async: tvalid %b idle %b read %b want 0/1/0", m_tvalid, ap_idle, fifo_read);
        end
        @(posedge clk); #1 reset = 1'b0;
        rdy_man = 1'b1;
        @(posedge clk); #1;
        g0 = got_q.size(); d0 = n_done;
        push(11'h155); push(11'h2AA);
        start(1, 2);
        wait_done(d0, 50, ok);
        repeat (2) @(posedge clk); #1;
        n = got_q.size() - g0;
        n_cmp++; if (!ok || n != 2) begin n_bad++; $display("FAIL rmid_new_count: ok %0d beats %0d want 2", ok, n); end
        if (n == 2) begin
            n_cmp++;
            if (got_q[g0] !== beat_t'({11'h155, 1'b0, 1'b1}) || got_q[g0+1] !== beat_t'({11'h2AA, 1'b1, 1'b0})) begin
                n_bad++; $display("FAIL rmid_new_beats: got %h %h want %h %h", got_q[g0], got_q[g0+1],
                                  beat_t'({11'h155, 1'b0, 1'b1}), beat_t'({11'h2AA, 1'b1, 1'b0}));
            end
        end
    endtask

`ifdef PP_FIFO2AXIS_PERF_EN
    task automatic test_perf();
        int d0, rd0, k;
        bit ok;
        man = 1; rdy_man = 1'b1; hold_man = 1'b0;
        @(posedge clk); #1;
        rd0 = rd; d0 = n_done;
        for (int i = 0; i < 8; i++) push(DW'($urandom));
        start(2, 4);
        for (k = 0; k < 50 && rd - rd0 < 3; k++) begin @(posedge clk); #1; end
        hold_man = 1'b1;
        repeat (7) @(posedge clk);
        #1 hold_man = 1'b0;
        for (k = 0; k < 50 && !(rd - rd0 >= 5 && m_tvalid); k++) begin @(posedge clk); #1; end
        rdy_man = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy_man = 1'b1;
        wait_done(d0, 100, ok);
        @(posedge clk); #1;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL perf_done: no ap_done within 100 cycles"); end
        n_cmp++; if (starve_cycles !== 32'd7) begin n_bad++; $display("FAIL perf_starve: %0d want 7", starve_cycles); end
        n_cmp++; if (stall_cycles !== 32'd3) begin n_bad++; $display("FAIL perf_stall: %0d want 3", stall_cycles); end
        rdy_man = 1'b0;
        repeat (4) @(posedge clk); #1;
        n_cmp++; if (starve_cycles !== 32'd7 || stall_cycles !== 32'd3) begin
            n_bad++; $display("FAIL perf_hold: starve %0d stall %0d want 7/3", starve_cycles, stall_cycles);
        end
        rdy_man = 1'b1;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_single();
        test_zero_dim();
        test_random();
        test_reset_mid();
`ifdef PP_FIFO2AXIS_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
